// File: rtl/fn_alu_pipe.sv
// Two-stage bitwise ALU pipeline with valid/ready handshake, chaining accumulator
// and a wrapping delivered-result counter.
module fn_alu_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             acc_en,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] res_cnt
);

    logic             adv;
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [2:0]       s1_sel_q;
    logic             s1_acc_en_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_zero_q;
    logic             out_parity_q;
    logic [CNT_W-1:0] res_cnt_q;

    // Whole pipe moves as one; S2 only blocks when it holds an unconsumed result.
    always_comb begin
        adv = !out_valid_q || out_ready;
    end

    always_comb begin
        op_a   = s1_acc_en_q ? acc_q : s1_a_q;
        result = op_a;
        case (s1_sel_q)
            3'b000:  result = op_a & s1_b_q;
            3'b001:  result = op_a | s1_b_q;
            3'b010:  result = op_a ^ s1_b_q;
            3'b011:  result = ~(op_a ^ s1_b_q);
            3'b100:  result = ~(op_a & s1_b_q);
            3'b101:  result = ~(op_a | s1_b_q);
            3'b110:  result = op_a & ~s1_b_q;
            default: result = op_a;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_a_q       <= '0;
            s1_b_q       <= '0;
            s1_sel_q     <= 3'b000;
            s1_acc_en_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_zero_q   <= 1'b0;
            out_parity_q <= 1'b0;
            acc_q        <= '0;
            res_cnt_q    <= '0;
        end else begin
            if (adv) begin
                s1_valid_q   <= in_valid;
                s1_a_q       <= a;
                s1_b_q       <= b;
                s1_sel_q     <= sel;
                s1_acc_en_q  <= acc_en;
                out_valid_q  <= s1_valid_q;
                out_data_q   <= result;
                out_zero_q   <= (result == '0);
                out_parity_q <= ^result;
            end
            // Clear wins, but the beat moving into S2 already used the old acc above.
            if (acc_clr) begin
                acc_q <= '0;
            end else if (adv && s1_valid_q) begin
                acc_q <= result;
            end
            if (out_valid_q && out_ready) begin
                res_cnt_q <= res_cnt_q + CNT_W'(1);
            end
        end
    end

    assign in_ready   = adv;
    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_zero   = out_zero_q;
    assign out_parity = out_parity_q;
    assign res_cnt    = res_cnt_q;

endmodule
